// File: rtl/vga_capture_if.sv
// Frame-buffer write bus driven by vga_capture: one strobe per stored pixel.
interface vga_capture_if;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_capture.sv
// VGA frame grabber: stores one armed frame into a linear frame buffer, two-cycle latency.
// Optional VGA_CAPTURE_SUM_EN adds a 32-bit per-frame r+g+b checksum output (frame_sum).
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        capture_en,
    input  logic        err_clr,
    vga_capture_if.master fb,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
`ifdef VGA_CAPTURE_SUM_EN
    output logic [31:0] frame_sum,
`endif
    output logic        busy
);
    localparam int AW = 19;
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0] H_MAX  = CW'(H_ACTIVE);
    localparam logic [LW-1:0] L_MAX  = LW'(V_ACTIVE);
    localparam logic [AW-1:0] H_STEP = AW'(H_ACTIVE);

    typedef enum logic [1:0] {SEEK, ARMED, CAPTURE} state_t;

    // Stage 1: every input registered; stage 2: delayed copies for edge detection
    logic        s1_hsync, s1_vsync, s1_valid, s1_cap, s1_clr;
    logic [23:0] s1_rgb;
    logic        s2_vsync, s2_valid;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_valid <= 1'b0;
            s1_cap   <= 1'b0;
            s1_clr   <= 1'b0;
            s1_rgb   <= '0;
            s2_vsync <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_hsync <= hsync;
            s1_vsync <= vsync;
            s1_valid <= valid;
            s1_cap   <= capture_en;
            s1_clr   <= err_clr;
            s1_rgb   <= {vga_r, vga_g, vga_b};
            s2_vsync <= s1_vsync;
            s2_valid <= s1_valid;
        end
    end

    // Line timing comes entirely from valid; hsync is registered but carries no information here
    logic unused_hsync;
    assign unused_hsync = s1_hsync;

    logic vs_fall, v_rise, v_fall;
    assign vs_fall = s2_vsync & ~s1_vsync;
    assign v_rise  = s1_valid & ~s2_valid;
    assign v_fall  = ~s1_valid & s2_valid;

    state_t          state_reg;
    logic [CW-1:0]   col_reg;
    logic [LW-1:0]   line_reg;
    logic [AW-1:0]   line_base_reg;
    logic            skip_reg;
    logic            wr_en_reg, frame_done_reg, line_err_reg, frame_err_reg, busy_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic [23:0]     wr_data_reg;

    logic in_cap, skip_cur, in_pix, do_write, line_err_set, frame_err_set, done_set;

    // Decisions for the stage-1 sample; a line opening past the last row is skipped whole
    always_comb begin
        in_cap        = (state_reg == CAPTURE);
        skip_cur      = v_rise ? (line_reg == L_MAX) : skip_reg;
        in_pix        = s1_valid && !vs_fall;
        do_write      = (in_cap && in_pix && !skip_cur && (col_reg < H_MAX) && (line_reg < L_MAX))
                        || ((state_reg == ARMED) && v_rise);
        line_err_set  = in_cap && !vs_fall &&
                        ((in_pix && !skip_cur && (col_reg == H_MAX)) ||
                         (v_fall && !skip_reg && (col_reg != H_MAX)));
        frame_err_set = in_cap && ((v_rise && !vs_fall && (line_reg == L_MAX)) ||
                                   (vs_fall && (line_reg != L_MAX)));
        done_set      = in_cap && vs_fall && (line_reg == L_MAX);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg      <= SEEK;
            col_reg        <= '0;
            line_reg       <= '0;
            line_base_reg  <= '0;
            skip_reg       <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            frame_done_reg <= 1'b0;
            line_err_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            wr_en_reg      <= do_write;
            frame_done_reg <= done_set;
            line_err_reg   <= line_err_set  | (line_err_reg  & ~s1_clr);
            frame_err_reg  <= frame_err_set | (frame_err_reg & ~s1_clr);
            if (do_write) begin
                wr_addr_reg <= line_base_reg + AW'(col_reg);
                wr_data_reg <= s1_rgb;
            end
            case (state_reg)
                SEEK: begin
                    busy_reg      <= 1'b0;
                    col_reg       <= '0;
                    line_reg      <= '0;
                    line_base_reg <= '0;
                    skip_reg      <= 1'b0;
                    if (vs_fall && s1_cap)
                        state_reg <= ARMED;
                end
                ARMED: begin
                    if (v_rise) begin
                        state_reg <= CAPTURE;
                        busy_reg  <= 1'b1;
                        col_reg   <= CW'(1);
                        skip_reg  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vs_fall) begin
                        state_reg     <= s1_cap ? ARMED : SEEK;
                        busy_reg      <= 1'b0;
                        col_reg       <= '0;
                        line_reg      <= '0;
                        line_base_reg <= '0;
                        skip_reg      <= 1'b0;
                    end else begin
                        if (v_rise)
                            skip_reg <= (line_reg == L_MAX);
                        if (do_write)
                            col_reg <= col_reg + CW'(1);
                        if (v_fall && !skip_reg) begin
                            line_reg      <= line_reg + LW'(1);
                            line_base_reg <= line_base_reg + H_STEP;
                            col_reg       <= '0;
                        end
                    end
                end
                default: begin
                    state_reg <= SEEK;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_CAPTURE_SUM_EN
    logic [31:0] sum_acc_reg, frame_sum_reg, pix_sum;
    assign pix_sum = 32'(s1_rgb[23:16]) + 32'(s1_rgb[15:8]) + 32'(s1_rgb[7:0]);

    // Accumulator restarts with the first pixel of each captured frame
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sum_acc_reg   <= '0;
            frame_sum_reg <= '0;
        end else begin
            if (done_set)
                frame_sum_reg <= sum_acc_reg;
            if (do_write)
                sum_acc_reg <= ((state_reg == ARMED) ? 32'd0 : sum_acc_reg) + pix_sum;
            else if (vs_fall)
                sum_acc_reg <= '0;
        end
    end
    assign frame_sum = frame_sum_reg;
`endif

    assign fb.wr_en   = wr_en_reg;
    assign fb.wr_addr = wr_addr_reg;
    assign fb.wr_data = wr_data_reg;
    assign frame_done = frame_done_reg;
    assign line_err   = line_err_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = busy_reg;
endmodule
